// File: rtl/niosii_esercitazione_buttons.sv
`default_nettype none
// ============================================================================
// Module      : niosii_esercitazione_buttons
// Description : Avalon-MM push-button input port. Synchronizes the active-low
//               button pins, optionally debounces them, captures falling
//               edges per bit and raises a maskable level interrupt.
//               Build option: define BUTTONS_DEBOUNCE_EN to instantiate the
//               per-bit debounce counters; otherwise the synchronized pins
//               feed the filtered state directly.
// Revision    : 1.0 - initial release
// ============================================================================
module niosii_esercitazione_buttons #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_DIR  = 2'd1;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_state_d;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;

    logic             w_write;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clear;
    logic [31:0]      w_rd_next;
    logic             w_unused;

    // Two-flop synchronizer and previous-state register; all reset to
    // "released" so the first real press is the first edge seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= '1;
            r_s2      <= '1;
            r_state_d <= '1;
        end else begin
            r_s1      <= in_port;
            r_s2      <= r_s1;
            r_state_d <= r_state;
        end
    end

`ifdef BUTTONS_DEBOUNCE_EN
    localparam int                c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = {c_CNT_W{1'b1}};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt [WIDTH];

    // Per-bit debounce: a mismatch must persist DEBOUNCE_CYCLES cycles before
    // the filtered state follows; any return to equality restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_s2[i] == r_state[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_LAST) begin
                    r_state[i] <= r_s2[i];
                    r_cnt[i]   <= '0;
                end else if (r_cnt[i] != c_CNT_MAX) begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end
            end
        end
    end
`else
    // No filtering: the filtered state simply follows the synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= '1;
        end else begin
            r_state <= r_s2;
        end
    end
`endif

    assign w_write = chipselect && !write_n;
    assign w_fall  = r_state_d & ~r_state;
    assign w_clear = (w_write && (address == c_ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register and edge capture (a new edge beats a clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            if (w_write && (address == c_ADDR_MASK)) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            r_edgecap <= (r_edgecap & ~w_clear) | w_fall;
        end
    end

    // Read multiplexer; upper bits are zero-extended.
    always_comb begin
        w_rd_next = '0;
        case (address)
            c_ADDR_DATA: w_rd_next = 32'(r_state);
            c_ADDR_DIR:  w_rd_next = '0;
            c_ADDR_MASK: w_rd_next = 32'(r_irqmask);
            c_ADDR_EDGE: w_rd_next = 32'(r_edgecap);
            default:     w_rd_next = '0;
        endcase
    end

    // Read data is registered every cycle regardless of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_next;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_irqmask);

    // Write data above WIDTH and the debounce depth (when filtering is not
    // built) have no function here.
    assign w_unused = ^{writedata, 1'(DEBOUNCE_CYCLES > 0)};

endmodule
`default_nettype wire

// File: tb/tb_niosii_esercitazione_buttons.sv
`default_nettype none
// ============================================================================
// Module      : tb_niosii_esercitazione_buttons
// Description : Directed self-checking bench for niosii_esercitazione_buttons
//               (WIDTH=2, DEBOUNCE_CYCLES=4). Expected latencies follow the
//               BUTTONS_DEBOUNCE_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_niosii_esercitazione_buttons;

    localparam int c_WIDTH = 2;
    localparam int c_DEB   = 4;
`ifdef BUTTONS_DEBOUNCE_EN
    localparam int       c_SL       = c_DEB + 1;  // edges from s1 sample to state
    localparam logic [31:0] c_GLITCH_EC = 32'h0;
`else
    localparam int       c_SL       = 2;
    localparam logic [31:0] c_GLITCH_EC = 32'h2;
`endif
    localparam int c_EC_SET = c_SL + 1;         // edges from s1 sample to edgecapture

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [31:0]        writedata;
    logic [31:0]        readdata;
    logic [c_WIDTH-1:0] in_port;
    logic               irq;

    int n_total = 0;
    int n_bad   = 0;

    niosii_esercitazione_buttons #(
        .WIDTH           (c_WIDTH),
        .DEBOUNCE_CYCLES (c_DEB)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
        chk(tag, readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 2'b11;
        repeat (3) tick();
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;
        repeat (4) tick();

        // Register reset values
        rd_chk("rst_data", 2'd0, 32'h3);
        rd_chk("rst_dir",  2'd1, 32'h0);
        rd_chk("rst_mask", 2'd2, 32'h0);
        rd_chk("rst_edge", 2'd3, 32'h0);

        // Press bit 0 and watch EDGECAPTURE appear at the exact cycle
        in_port[0] = 1'b0;
        address    = 2'd3;
        chipselect = 1'b1;
        for (int t = 1; t <= c_EC_SET + 2; t++) begin
            tick();
            if (t == c_EC_SET + 1) chk("edge_early", readdata, 32'h0);
            if (t == c_EC_SET + 2) chk("edge_set", readdata, 32'h1);
        end
        chipselect = 1'b0;
        chk("irq_masked", {31'd0, irq}, 32'h0);
        rd_chk("data_pressed", 2'd0, 32'h2);

        // Writes without chipselect and to DIRECTION are ignored
        address   = 2'd2;
        writedata = 32'h3;
        write_n   = 1'b0;
        tick();
        write_n   = 1'b1;
        rd_chk("mask_nocs", 2'd2, 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        rd_chk("dir_ignored", 2'd1, 32'h0);

        // Mask, then write-1-to-clear behaviour
        wr(2'd2, 32'h1);
        chk("irq_on", {31'd0, irq}, 32'h1);
        wr(2'd3, 32'h2);
        chk("irq_other_clr", {31'd0, irq}, 32'h1);
        rd_chk("edge_kept", 2'd3, 32'h1);
        wr(2'd3, 32'h1);
        chk("irq_cleared", {31'd0, irq}, 32'h0);
        rd_chk("edge_cleared", 2'd3, 32'h0);

        // Release bit 0, then a 3-cycle glitch on bit 1
        in_port = 2'b11;
        repeat (12) tick();
        rd_chk("edge_release", 2'd3, 32'h0);
        in_port[1] = 1'b0;
        repeat (3) tick();
        in_port[1] = 1'b1;
        repeat (12) tick();
        rd_chk("glitch_data", 2'd0, 32'h3);
        rd_chk("glitch_edge", 2'd3, c_GLITCH_EC);
        wr(2'd3, 32'h3);

        // Clear coincides with a new capture on bit 0: the capture wins
        in_port[0] = 1'b0;
        repeat (c_EC_SET) tick();
        wr(2'd3, 32'h1);
        rd_chk("set_wins", 2'd3, 32'h1);
        chk("set_wins_irq", {31'd0, irq}, 32'h1);

        // Reset in the middle of bit 1's debounce count
        wr(2'd2, 32'h3);
        chk("pre_rst_irq", {31'd0, irq}, 32'h1);
        in_port[1] = 1'b0;
        repeat (4) tick();
        address = 2'd3;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        chk("mid_rst_rd", readdata, 32'h0);
        chk("mid_rst_irq", {31'd0, irq}, 32'h0);
        tick();
        chk("mid_rst_edge", readdata, 32'h0);
        address = 2'd0;
        for (int t = 2; t <= c_SL + 2; t++) begin
            tick();
            if (t == c_SL + 1) chk("recount_early", readdata, 32'h3);
            if (t == c_SL + 2) chk("recount_done", readdata, 32'h0);
        end
        rd_chk("mid_rst_mask", 2'd2, 32'h0);
        rd_chk("mid_rst_dir",  2'd1, 32'h0);
        chk("post_rst_irq", {31'd0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/niosii_esercitazione_buttons.md
# niosii_esercitazione_buttons

Avalon-MM slave input port for the DE10-Lite push-buttons, the read-side counterpart of the LED output port on the Nios II system bus. It synchronizes the asynchronous `in_port` pins, optionally debounces them, captures falling edges per bit, and raises a maskable level interrupt to the CPU. Software reads the filtered pin state, programs the interrupt mask, and clears captured edges through four word registers.

## Interface
Parameters:
- `WIDTH`, 2: number of input bits (1..32).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before a bit change is accepted (10 ms at 50 MHz); ≥1. Used only when debounce is compiled in.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  2  word register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write is `chipselect && !write_n`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data; bits above `WIDTH` are 0.
- `in_port`  in  WIDTH  raw asynchronous button pins, active-low (pressed = 0).
- `irq`  out  1  level interrupt, high while any unmasked edge is captured.

## Operation
- Input path: 2-FF synchronizer `s1`→`s2` per bit, then filtered `state`, then `state_d` (previous `state`) for edge detection.
- Debounce (per bit): counter clears while `s2 == state`; increments while `s2 != state`; when it reaches `DEBOUNCE_CYCLES-1` with the mismatch still present, `state <= s2` and the counter clears. Any return to equality before that point clears the counter, so glitches shorter than `DEBOUNCE_CYCLES` cycles are discarded. Counter width is `$clog2(DEBOUNCE_CYCLES+1)` and it saturates without wrapping.
- Edge detect: falling edge on bit i when `state_d[i]==1 && state[i]==0`.
- Register map (word addresses):
  - 0 DATA: read `state`; writes ignored.
  - 1 DIRECTION: reads 0; writes ignored (input-only port).
  - 2 IRQMASK: R/W, `WIDTH` bits.
  - 3 EDGECAPTURE: read captured edges; a write clears each bit where `writedata[i]==1` (write-1-to-clear).
- Edge capture bit sets on detected falling edge and holds until cleared. Simultaneous set and clear on the same bit in the same cycle: set wins.
- `irq = |(edgecapture & irqmask)`, driven combinationally from registers only (glitch-free).
- Writes with `chipselect` low, or reads of an unmapped bit, have no effect and return 0.

## Timing
- Reset values: `s1`, `s2`, `state`, `state_d` = all ones (buttons released); counters 0; `irqmask` 0; `edgecapture` 0; `readdata` 0; `irq` 0.
- The first edge after reset is not falsely captured, because the pipeline resets to released.
- Read latency is 1 cycle: `readdata` is loaded on every clock from `address` (ignoring `chipselect`) and is valid the cycle after `address` is presented. There are no wait states.
- Write takes effect on the clock edge where the write is asserted; `irq` reflects mask and clear changes on the following cycle.
- Debounced pin change at edge k into `s1`: `s2` at k+1, `state` at k+1+`DEBOUNCE_CYCLES`, `edgecapture` and `irq` at k+2+`DEBOUNCE_CYCLES`.
- `reset` asserted mid-count: all counters and captures return to reset values on that edge, and any pending interrupt drops in the next cycle.

## Configuration
- `BUTTONS_DEBOUNCE_EN` defined: debounce counters are instantiated as described.
- Not defined: `state <= s2` every cycle, no counters, and `DEBOUNCE_CYCLES` is ignored. The pin-to-`state` latency is 2 cycles, and `edgecapture` sets on cycle 3 after the pin change.

## Test plan
Bench with `WIDTH`=2 and `DEBOUNCE_CYCLES`=4.
- Reset, then read addresses 0/1/2/3 → `readdata` = 0x3/0x0/0x0/0x0, `irq`=0.
- Pull `in_port[0]` low and hold → DATA reads 0x2, EDGECAPTURE reads 0x1 exactly 4+2 cycles after `s1` samples the low, and `irq` stays 0 (mask 0).
- Write IRQMASK=0x1 → `irq`=1 next cycle. Write EDGECAPTURE=0x2 → bit 0 stays set and `irq` stays 1. Write EDGECAPTURE=0x1 → `irq`=0 next cycle.
- With macro defined, apply a 3-cycle low glitch on `in_port[1]` → DATA stays 0x3, EDGECAPTURE stays 0x0. With macro undefined, the same glitch → EDGECAPTURE=0x2.
- Write EDGECAPTURE=0x1 in the same cycle a new falling edge on bit 0 is detected → bit 0 reads 1 afterwards (set wins).
- Assert `reset` while bit 1's counter is at 2 with IRQMASK=0x3 and EDGECAPTURE=0x1 → next cycle all registers read reset values, `irq`=0, and the held-low pin requires a full 4-cycle count to be re-accepted.
